// File: rtl/gpia_pkg.sv
// Shared definitions for the GPIA byte write-port controllers.
// Holds the mode encoding (same as the GPIA_BIT cell), limits and the byte update rule.
package gpia_pkg;

  typedef enum logic [1:0] {
    GPIA_MODE_LOAD = 2'b00,
    GPIA_MODE_SET  = 2'b01,
    GPIA_MODE_CLR  = 2'b10,
    GPIA_MODE_TOG  = 2'b11
  } gpia_mode_e;

  localparam int GPIA_NREQ_MAX = 8;
  localparam int GPIA_GAP_W    = 4;

  // Next value of a GPIA_BYTE after one strobe with the given mode and data/mask.
  function automatic logic [7:0] gpia_apply(input logic [7:0] s,
                                            input logic [1:0] mode,
                                            input logic [7:0] d);
    logic [7:0] r;
    r = s;
    case (mode)
      GPIA_MODE_LOAD: r = d;
      GPIA_MODE_SET:  r = s | d;
      GPIA_MODE_CLR:  r = s & ~d;
      GPIA_MODE_TOG:  r = s ^ d;
      default:        r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpia_rr_pick.sv
// Combinational round-robin picker: first set bit of i_elig searching
// i_ptr+1, i_ptr+2, ... modulo N. Shared by GPIA controllers.
module gpia_rr_pick #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_elig,
  input  logic [W-1:0] i_ptr,
  output logic         o_valid,
  output logic [W-1:0] o_idx
);

  // Scan from the farthest offset down to the nearest so the last hit
  // written is the first in round-robin order.
  // NOTE: every output of an always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      int idx;
      idx = (int'(i_ptr) + k) % N;
      if (i_elig[idx]) begin
        o_valid = 1'b1;
        o_idx   = idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/gpia_byte_arbiter.sv
// Round-robin arbiter sharing the GPIA_BYTE write port between NREQ requesters.
// Optional feature macro: GPIA_ARB_SHADOW_EN (predicted byte value on shadow_o).
module gpia_byte_arbiter
  import gpia_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int GAP  = 0
) (
  input  logic              clk_i,
  input  logic              res_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [2*NREQ-1:0] mode_i,
  input  logic [8*NREQ-1:0] d_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [1:0]        mode_o,
  output logic [7:0]        d_o,
  output logic              stb_o,
  output logic              busy_o,
  output logic [7:0]        shadow_o
);

  localparam int                    PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0]      PTR_RST = PTR_W'(NREQ - 1);
  localparam logic [GPIA_GAP_W-1:0] GAP_V   = GAP[GPIA_GAP_W-1:0];

  logic [NREQ-1:0]       r_ack;
  logic                  r_stb;
  logic [1:0]            r_mode;
  logic [7:0]            r_d;
  logic [PTR_W-1:0]      r_ptr;
  logic [GPIA_GAP_W-1:0] r_gap;

  logic                  w_busy;
  logic [NREQ-1:0]       w_elig;
  logic                  w_valid;
  logic [PTR_W-1:0]      w_idx;
  logic [NREQ-1:0]       w_ack_nxt;
  logic [1:0]            w_mode_sel;
  logic [7:0]            w_d_sel;

  // The requester acked this cycle is masked so a held req is not granted twice.
  assign w_busy = (r_gap != '0);
  assign w_elig = req_i & ~r_ack & {NREQ{~w_busy}};

  gpia_rr_pick #(
    .N (NREQ),
    .W (PTR_W)
  ) u_pick (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_ack_nxt  = '0;
    w_mode_sel = '0;
    w_d_sel    = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (w_valid && (int'(w_idx) == n)) begin
        w_ack_nxt[n] = 1'b1;
        w_mode_sel   = mode_i[2*n +: 2];
        w_d_sel      = d_i[8*n +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the clock edge.
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      r_stb  <= 1'b0;
      r_ack  <= '0;
      r_mode <= '0;
      r_d    <= '0;
      r_ptr  <= PTR_RST;
      r_gap  <= '0;
    end else begin
      r_stb <= w_valid;
      r_ack <= w_ack_nxt;
      if (w_valid) begin
        r_mode <= w_mode_sel;
        r_d    <= w_d_sel;
        r_ptr  <= w_idx;
        r_gap  <= GAP_V;
      end else if (w_busy) begin
        r_gap <= r_gap - 1'b1;
      end
    end
  end

  assign ack_o  = r_ack;
  assign stb_o  = r_stb;
  assign mode_o = r_mode;
  assign d_o    = r_d;
  assign busy_o = w_busy;

`ifdef GPIA_ARB_SHADOW_EN
  logic [7:0] r_shadow;

  // Tracks the byte: it applies mode_o/d_o at the end of the strobe cycle.
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      r_shadow <= 8'h00;
    end else if (r_stb) begin
      r_shadow <= gpia_apply(r_shadow, r_mode, r_d);
    end
  end

  assign shadow_o = r_shadow;
`else
  assign shadow_o = 8'h00;
`endif

endmodule
